// File: rtl/snake_pkg.sv
// Shared types and defaults for the snake game core: headings, collision codes, cell coordinates.
// Helpers convert cell indices to pixels and test whether a scan pixel lies inside a cell.
package snake_pkg;

   localparam int DEF_MAX_LEN  = 32;
   localparam int DEF_GRID_W   = 40;
   localparam int DEF_GRID_H   = 30;
   localparam int DEF_START_X  = 20;
   localparam int DEF_START_Y  = 15;
   localparam int DEF_APPLE_X0 = 10;
   localparam int DEF_APPLE_Y0 = 10;
   localparam int DEF_COOLDOWN = 10;

   localparam logic [10:0] LFSR_SEED = 11'h5A5;

   typedef enum logic [3:0] {
      DIR_UP    = 4'b0001,
      DIR_DOWN  = 4'b0010,
      DIR_LEFT  = 4'b0100,
      DIR_RIGHT = 4'b1000
   } dir_t;

   typedef enum logic [1:0] {
      COL_NONE  = 2'b00,
      COL_APPLE = 2'b01,
      COL_WALL  = 2'b10
   } coll_t;

   typedef struct packed {
      logic [10:0] x;
      logic [10:0] y;
   } coord_t;

   function automatic dir_t dir_reverse(input dir_t d);
      case (d)
         DIR_UP:   return DIR_DOWN;
         DIR_DOWN: return DIR_UP;
         DIR_LEFT: return DIR_RIGHT;
         default:  return DIR_LEFT;
      endcase
   endfunction

   // Pixel arithmetic wraps at 11 bits, matching the scan address width.
   function automatic logic [10:0] cell2pix(input logic [10:0] c, input logic [10:0] cs);
      logic [21:0] p;
      p = {11'd0, c} * {11'd0, cs};
      return p[10:0];
   endfunction

   function automatic logic in_cell(input logic [10:0] col, input logic [10:0] row,
                                    input coord_t c, input logic [10:0] cs);
      logic [10:0] dx;
      logic [10:0] dy;
      dx = col - c.x;
      dy = row - c.y;
      return (dx < cs) && (dy < cs);
   endfunction

endpackage

// File: rtl/snake_game_core_if.sv
// Scan, control and status signals between the VGA front end and the snake core.
// master drives addresses/strobes/requests; slave (the core) returns pixel flags and game status.
interface snake_game_core_if;
   logic        move_tick;
   logic        apple_tick;
   logic [10:0] col_addr;
   logic [10:0] row_addr;
   logic [3:0]  dir;
   logic [10:0] cell_size;
   logic        border;
   logic        snake_head;
   logic        snake_body;
   logic        apple;
   logic        game_over;
   logic [7:0]  length;

   modport master (
      output move_tick, apple_tick, col_addr, row_addr, dir, cell_size, border,
      input  snake_head, snake_body, apple, game_over, length
   );

   modport slave (
      input  move_tick, apple_tick, col_addr, row_addr, dir, cell_size, border,
      output snake_head, snake_body, apple, game_over, length
   );
endinterface

// File: rtl/snake_apple_gen.sv
// Apple placement: free-running LFSR sampled on apple_tick while a refresh is pending; registered hit test.
// Apple flag lags the scan address by 1 cycle; a rejected sample simply retries on the next apple_tick.
module snake_apple_gen
   import snake_pkg::*;
#(
   parameter int GRID_W   = DEF_GRID_W,
   parameter int GRID_H   = DEF_GRID_H,
   parameter int APPLE_X0 = DEF_APPLE_X0,
   parameter int APPLE_Y0 = DEF_APPLE_Y0
) (
   input  logic        vga_clk,
   input  logic        rst_n,
   input  logic        reset,
   input  logic        refresh,
   input  logic        apple_tick,
   input  logic [10:0] col_addr,
   input  logic [10:0] row_addr,
   input  logic [10:0] cell_size,
   output logic        apple_hit
);

   logic [10:0] lfsr_q;
   logic        pending_q;
   logic [10:0] ax_q;
   logic [10:0] ay_q;
   logic [10:0] cx;
   logic [10:0] cy;
   logic        accept;
   coord_t      apple_pix;

   assign cx = {5'd0, lfsr_q[5:0]};
   assign cy = {6'd0, lfsr_q[10:6]};
   // Keep apples off the outer ring of cells, where the wall sits.
   assign accept = apple_tick && pending_q
                && (cx >= 11'd1) && (cx <= 11'(GRID_W - 2))
                && (cy >= 11'd1) && (cy <= 11'(GRID_H - 2));
   assign apple_pix = {cell2pix(ax_q, cell_size), cell2pix(ay_q, cell_size)};

   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q    <= LFSR_SEED;
         pending_q <= 1'b0;
         ax_q      <= 11'(APPLE_X0);
         ay_q      <= 11'(APPLE_Y0);
         apple_hit <= 1'b0;
      end else if (reset) begin
         lfsr_q    <= LFSR_SEED;
         pending_q <= 1'b0;
         ax_q      <= 11'(APPLE_X0);
         ay_q      <= 11'(APPLE_Y0);
         apple_hit <= 1'b0;
      end else begin
         lfsr_q    <= {lfsr_q[9:0], lfsr_q[10] ^ lfsr_q[8]};
         pending_q <= refresh | (pending_q & ~accept);
         if (accept) begin
            ax_q <= cx;
            ay_q <= cy;
         end
         apple_hit <= in_cell(col_addr, row_addr, apple_pix, cell_size);
      end
   end

endmodule

// File: rtl/snake_game_core.sv
// Snake game logic: segments, steering, collision, growth, sticky game-over. Option: SNAKE_SELF_COLLISION_EN.
// Pixel flags registered (1 cycle from address); no backpressure, ticks are single-cycle strobes.
module snake_game_core
   import snake_pkg::*;
#(
   parameter int MAX_LEN  = DEF_MAX_LEN,
   parameter int GRID_W   = DEF_GRID_W,
   parameter int GRID_H   = DEF_GRID_H,
   parameter int START_X  = DEF_START_X,
   parameter int START_Y  = DEF_START_Y,
   parameter int APPLE_X0 = DEF_APPLE_X0,
   parameter int APPLE_Y0 = DEF_APPLE_Y0,
   parameter int COOLDOWN = DEF_COOLDOWN
) (
   input  logic              vga_clk,
   input  logic              rst_n,
   input  logic              reset,
   snake_game_core_if.slave  bus
);

   localparam int CW = $clog2(COOLDOWN + 1);

   typedef enum logic {ST_PLAY, ST_OVER} state_t;

   state_t      state_q, state_d;
   dir_t        heading_q;
   logic [10:0] hx_q, hy_q;
   coord_t      head_pix;
   coord_t      seg_q [1:MAX_LEN-1];
   logic [7:0]  length_q, length_d;
   logic [CW-1:0] cool_q;
   logic        head_q, body_q, border_q, apple_q;
   logic        body_hit, wall_hit, refresh;
   coll_t       coll;

   // Head kept in cell units so its reset value is independent of cell_size.
   assign head_pix = {cell2pix(hx_q, bus.cell_size), cell2pix(hy_q, bus.cell_size)};

   always_comb begin
      body_hit = 1'b0;
      for (int i = 1; i < MAX_LEN; i++) begin
         if (8'(i) < length_q && in_cell(bus.col_addr, bus.row_addr, seg_q[i], bus.cell_size))
            body_hit = 1'b1;
      end
   end

   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q   <= 1'b0;
         body_q   <= 1'b0;
         border_q <= 1'b0;
      end else if (reset) begin
         head_q   <= 1'b0;
         body_q   <= 1'b0;
         border_q <= 1'b0;
      end else begin
         head_q   <= in_cell(bus.col_addr, bus.row_addr, head_pix, bus.cell_size);
         body_q   <= body_hit;
         border_q <= bus.border;
      end
   end

   snake_apple_gen #(
      .GRID_W   (GRID_W),
      .GRID_H   (GRID_H),
      .APPLE_X0 (APPLE_X0),
      .APPLE_Y0 (APPLE_Y0)
   ) u_apple (
      .vga_clk    (vga_clk),
      .rst_n      (rst_n),
      .reset      (reset),
      .refresh    (refresh),
      .apple_tick (bus.apple_tick),
      .col_addr   (bus.col_addr),
      .row_addr   (bus.row_addr),
      .cell_size  (bus.cell_size),
      .apple_hit  (apple_q)
   );

`ifdef SNAKE_SELF_COLLISION_EN
   assign wall_hit = head_q & (border_q | body_q);
`else
   assign wall_hit = head_q & border_q;
`endif

   always_comb begin
      coll = COL_NONE;
      if (cool_q == '0 && state_q == ST_PLAY) begin
         if (wall_hit)
            coll = COL_WALL;
         else if (head_q && apple_q)
            coll = COL_APPLE;
      end
   end

   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_PLAY;
         length_q <= 8'd1;
         cool_q   <= '0;
      end else if (reset) begin
         state_q  <= ST_PLAY;
         length_q <= 8'd1;
         cool_q   <= '0;
      end else begin
         state_q  <= state_d;
         length_q <= length_d;
         if (coll != COL_NONE)
            cool_q <= CW'(COOLDOWN);
         else if (cool_q != '0)
            cool_q <= cool_q - 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      length_d = length_q;
      refresh  = 1'b0;
      case (state_q)
         ST_PLAY: begin
            if (coll == COL_WALL) begin
               state_d = ST_OVER;
            end else if (coll == COL_APPLE) begin
               refresh = 1'b1;
               if (length_q < 8'(MAX_LEN))
                  length_d = length_q + 8'd1;
            end
         end
         ST_OVER: state_d = ST_OVER;
      endcase
   end

   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         heading_q <= DIR_RIGHT;
         hx_q      <= 11'(START_X);
         hy_q      <= 11'(START_Y);
         for (int i = 1; i < MAX_LEN; i++) seg_q[i] <= '0;
      end else if (reset) begin
         heading_q <= DIR_RIGHT;
         hx_q      <= 11'(START_X);
         hy_q      <= 11'(START_Y);
         for (int i = 1; i < MAX_LEN; i++) seg_q[i] <= '0;
      end else begin
         if ($onehot(bus.dir) && bus.dir != dir_reverse(heading_q))
            heading_q <= dir_t'(bus.dir);
         if (bus.move_tick && state_q == ST_PLAY) begin
            seg_q[1] <= head_pix;
            for (int i = 2; i < MAX_LEN; i++) seg_q[i] <= seg_q[i-1];
            case (heading_q)
               DIR_UP:   hy_q <= hy_q - 11'd1;
               DIR_DOWN: hy_q <= hy_q + 11'd1;
               DIR_LEFT: hx_q <= hx_q - 11'd1;
               default:  hx_q <= hx_q + 11'd1;
            endcase
         end
      end
   end

   assign bus.snake_head = head_q;
   assign bus.snake_body = body_q;
   assign bus.apple      = apple_q;
   assign bus.game_over  = (state_q == ST_OVER);
   assign bus.length     = length_q;

endmodule

// File: tb/tb_snake_game_core.sv
// Directed bench for snake_game_core with cell_size=16; apple placement predicted by a reference LFSR.
module tb_snake_game_core;
   import snake_pkg::*;

`ifdef SNAKE_SELF_COLLISION_EN
   localparam logic SELF_COLL = 1'b1;
`else
   localparam logic SELF_COLL = 1'b0;
`endif

   logic vga_clk = 1'b0;
   logic rst_n   = 1'b0;
   logic reset   = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [10:0] m_lfsr;

   snake_game_core_if bus ();

   snake_game_core dut (
      .vga_clk (vga_clk),
      .rst_n   (rst_n),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 vga_clk = ~vga_clk;

   always @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n)     m_lfsr <= 11'h5A5;
      else if (reset) m_lfsr <= 11'h5A5;
      else            m_lfsr <= {m_lfsr[9:0], m_lfsr[10] ^ m_lfsr[8]};
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge vga_clk);
         #1;
      end
   endtask

   task automatic park();
      bus.col_addr = 11'd2000;
      bus.row_addr = 11'd2000;
      bus.border   = 1'b0;
   endtask

   task automatic scan(input int x, input int y, input logic b);
      bus.col_addr = 11'(x);
      bus.row_addr = 11'(y);
      bus.border   = b;
      cyc(1);
   endtask

   task automatic move(input logic [3:0] d, input int n);
      park();
      bus.dir = d;
      cyc(1);
      bus.dir = 4'b0000;
      repeat (n) begin
         bus.move_tick = 1'b1;
         cyc(1);
         bus.move_tick = 1'b0;
      end
   endtask

   task automatic eat(input int x, input int y);
      scan(x, y, 1'b0);
      cyc(7);
      park();
      cyc(15);
   endtask

   task automatic pulse_apple_tick();
      bus.apple_tick = 1'b1;
      cyc(1);
      bus.apple_tick = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   initial begin
      logic [10:0] snap;
      int          ex, ey, cx, cy;
      logic        accepted;

      bus.move_tick  = 1'b0;
      bus.apple_tick = 1'b0;
      bus.dir        = 4'b0000;
      bus.cell_size  = 11'd16;
      park();
      cyc(3);
      chk("rst_length", bus.length, 1);
      chk("rst_game_over", bus.game_over, 0);
      chk("rst_head_px", bus.snake_head, 0);
      chk("rst_body_px", bus.snake_body, 0);
      chk("rst_apple_px", bus.apple, 0);
      rst_n = 1'b1;
      cyc(1);

      // Start cell (20,15) and apple cell (10,10), including cell-edge boundaries.
      scan(320, 240, 1'b0);  chk("a_head_start", bus.snake_head, 1);
                             chk("a_body_start", bus.snake_body, 0);
      scan(335, 255, 1'b0);  chk("a_head_edge_in", bus.snake_head, 1);
      scan(336, 240, 1'b0);  chk("a_head_edge_out_x", bus.snake_head, 0);
      scan(320, 256, 1'b0);  chk("a_head_edge_out_y", bus.snake_head, 0);
      scan(319, 240, 1'b0);  chk("a_head_below_x", bus.snake_head, 0);
      scan(160, 160, 1'b0);  chk("a_apple_start", bus.apple, 1);
                             chk("a_head_not_apple", bus.snake_head, 0);

      // Steering: up accepted, reverse and multi-hot requests ignored.
      move(DIR_UP, 1);
      scan(320, 224, 1'b0);  chk("b_head_up", bus.snake_head, 1);
      scan(320, 240, 1'b0);  chk("b_old_head", bus.snake_head, 0);
                             chk("b_no_body_len1", bus.snake_body, 0);
      move(DIR_DOWN, 1);
      scan(320, 208, 1'b0);  chk("b_reverse_ignored", bus.snake_head, 1);
      move(4'b0011, 1);
      scan(320, 192, 1'b0);  chk("b_multihot_ignored", bus.snake_head, 1);

      // Walk onto the apple and eat four times; cooldown keeps each eat to +1.
      move(DIR_UP, 2);
      move(DIR_LEFT, 10);
      for (int k = 1; k <= 4; k++) begin
         eat(165, 170);
         chk($sformatf("c_len_after_eat%0d", k), bus.length, 1 + k);
      end

      // Loop back onto own tail with length 5.
      move(DIR_UP, 1);
      move(DIR_LEFT, 1);
      move(DIR_DOWN, 1);
      move(DIR_RIGHT, 1);
      move(DIR_UP, 1);
      scan(160, 144, 1'b0);  chk("d_head_on_loop", bus.snake_head, 1);
                             chk("d_body_on_loop", bus.snake_body, 1);
      park();
      cyc(3);
      chk("d_self_game_over", bus.game_over, SELF_COLL);
      chk("d_len_kept", bus.length, 5);
      scan(160, 160, 1'b0);  chk("d_apple_held_pending", bus.apple, 1);
                             chk("d_body_seg1", bus.snake_body, 1);

      // Synchronous restart while a refresh is pending.
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      chk("e_len_reset", bus.length, 1);
      chk("e_over_reset", bus.game_over, 0);
      scan(320, 240, 1'b0);  chk("e_head_reset", bus.snake_head, 1);
      scan(160, 144, 1'b0);  chk("e_body_gone", bus.snake_body, 0);
      park();
      repeat (5) pulse_apple_tick();
      scan(160, 160, 1'b0);  chk("e_pending_cleared", bus.apple, 1);

      // Eat once, move off, then relocate the apple via apple_tick.
      move(DIR_UP, 5);
      move(DIR_LEFT, 10);
      eat(160, 160);
      chk("f_len_eat", bus.length, 2);
      move(DIR_UP, 1);
      park();
      accepted = 1'b0;
      ex = 0;
      ey = 0;
      for (int k = 0; k < 40 && !accepted; k++) begin
         snap = m_lfsr;
         pulse_apple_tick();
         cx = int'(snap[5:0]);
         cy = int'(snap[10:6]);
         if (cx >= 1 && cx <= 38 && cy >= 1 && cy <= 28) begin
            accepted = 1'b1;
            ex = cx;
            ey = cy;
         end else begin
            scan(160, 160, 1'b0);
            chk("f_apple_hold_on_reject", bus.apple, 1);
            park();
         end
      end
      scan(160, 160, 1'b0);
      chk("f_old_apple_cleared", bus.apple, (accepted && ex == 10 && ey == 10) ? 1 : 0);
      if (accepted) begin
         scan(ex * 16 + 3, ey * 16 + 5, 1'b0);
         chk("f_new_apple", bus.apple, 1);
      end
      park();

      // Wall and apple on the head pixel together: wall wins.
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      cyc(1);
      move(DIR_UP, 5);
      move(DIR_LEFT, 10);
      scan(160, 160, 1'b1);
      park();
      cyc(3);
      chk("h_over_wall_apple", bus.game_over, 1);
      chk("h_len_unchanged", bus.length, 1);
      move(DIR_UP, 2);
      scan(160, 160, 1'b0);  chk("h_head_frozen", bus.snake_head, 1);
      scan(160, 128, 1'b0);  chk("h_head_not_moved", bus.snake_head, 0);
      park();
      cyc(3);
      chk("h_len_frozen", bus.length, 1);
      rst_n = 1'b0;
      cyc(1);
      chk("h_over_async_clear", bus.game_over, 0);
      rst_n = 1'b1;
      cyc(1);

      // Plain wall hit, sticky through moves, cleared by synchronous restart.
      scan(330, 250, 1'b1);
      park();
      cyc(3);
      chk("g_over_wall", bus.game_over, 1);
      move(DIR_RIGHT, 1);
      scan(320, 240, 1'b0);  chk("g_head_frozen", bus.snake_head, 1);
      cyc(20);
      chk("g_over_sticky", bus.game_over, 1);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      chk("g_over_sync_clear", bus.game_over, 0);
      move(DIR_RIGHT, 1);
      scan(336, 240, 1'b0);  chk("g_moves_again", bus.snake_head, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
